// File: rtl/enc_pkg.sv
// Shared types for the encoder scheduler: mode encoding, per-mode widths and the
// per-request tag that travels alongside the encoder pipeline.
package enc_pkg;

    typedef enum logic [1:0] {
        MOD_NONE = 2'd0,
        MOD_1    = 2'd1,
        MOD_2    = 2'd2,
        MOD_3    = 2'd3
    } enc_mod_t;

    localparam int unsigned InfoW1 = 4;
    localparam int unsigned InfoW2 = 11;
    localparam int unsigned InfoW3 = 26;

    localparam int unsigned ParW1 = 4;
    localparam int unsigned ParW2 = 5;
    localparam int unsigned ParW3 = 6;

    // Wide enough for the largest supported requester count (8).
    localparam int unsigned TagIdW = 3;

    typedef struct packed {
        logic [TagIdW-1:0] id;
        enc_mod_t          mod;
        logic              err;
    } enc_tag_t;

    function automatic int unsigned info_width(enc_mod_t mod);
        int unsigned w;
        unique case (mod)
            MOD_1:   w = InfoW1;
            MOD_2:   w = InfoW2;
            MOD_3:   w = InfoW3;
            default: w = 0;
        endcase
        return w;
    endfunction

    function automatic int unsigned parity_width(enc_mod_t mod);
        int unsigned w;
        unique case (mod)
            MOD_1:   w = ParW1;
            MOD_2:   w = ParW2;
            MOD_3:   w = ParW3;
            default: w = 0;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/enc_sched_fifo.sv
// Synchronous response FIFO; count is exported so the scheduler can budget credit.
module enc_sched_fifo #(
    parameter int unsigned Width = 8,
    parameter int unsigned Depth = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [Width-1:0]           push_data,
    input  logic                       pop,
    output logic [Width-1:0]           pop_data,
    output logic                       empty,
    output logic [$clog2(Depth+1)-1:0] count
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned CntW = $clog2(Depth + 1);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_q, wr_d;
    logic [PtrW-1:0]  rd_q, rd_d;
    logic [CntW-1:0]  count_q, count_d;

    function automatic logic [PtrW-1:0] next_ptr(logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        wr_d    = wr_q;
        rd_d    = rd_q;
        count_d = count_q;
        if (push) begin
            wr_d = next_ptr(wr_q);
        end
        if (pop) begin
            rd_d = next_ptr(rd_q);
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: the read side is qualified by empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_q] <= push_data;
        end
    end

    assign pop_data = mem_q[rd_q];
    assign empty    = (count_q == '0);
    assign count    = count_q;

endmodule

// File: rtl/enc_sched.sv
// Round-robin scheduler sharing one pipelined ECC encoder among NUM_REQ requesters.
// Define ENC_SCHED_MASK_EN to zero info bits above the selected mode's width before issue.
module enc_sched
    import enc_pkg::*;
#(
    parameter int unsigned NUM_REQ            = 4,
    parameter int unsigned MAX_INFO_WIDTH     = 26,
    parameter int unsigned MAX_CODEWORD_WIDTH = 32,
    parameter int unsigned ENC_LATENCY        = 2,
    parameter int unsigned OUT_DEPTH          = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_REQ-1:0]                req_valid,
    output logic [NUM_REQ-1:0]                req_ready,
    input  logic [NUM_REQ*MAX_INFO_WIDTH-1:0] req_data,
    input  logic [NUM_REQ*2-1:0]              req_mod,
    output logic [MAX_INFO_WIDTH-1:0]         enc_data_in,
    output logic [1:0]                        enc_mod,
    input  logic [MAX_CODEWORD_WIDTH-1:0]     enc_data_out,
    output logic                              rsp_valid,
    input  logic                              rsp_ready,
    output logic [MAX_CODEWORD_WIDTH-1:0]     rsp_data,
    output logic [$clog2(NUM_REQ)-1:0]        rsp_id,
    output logic [1:0]                        rsp_mod,
    output logic                              rsp_err
);

    localparam int unsigned IdW   = $clog2(NUM_REQ);
    localparam int unsigned CntW  = $clog2(OUT_DEPTH + 1);
    localparam int unsigned SumW  = CntW + 1;
    localparam int unsigned TagW  = $bits(enc_tag_t);
    localparam int unsigned FifoW = MAX_CODEWORD_WIDTH + TagW;

    logic [IdW-1:0]            last_ptr_q, last_ptr_d;
    logic [CntW-1:0]           inflight_q, inflight_d;
    logic [MAX_INFO_WIDTH-1:0] enc_data_q, enc_data_d;
    enc_mod_t                  enc_mod_q, enc_mod_d;
    enc_tag_t                  tag_q [ENC_LATENCY+1];
    enc_tag_t                  tag_d [ENC_LATENCY+1];
    logic [ENC_LATENCY:0]      tag_vld_q, tag_vld_d;

    logic [CntW-1:0]           fifo_count;
    logic [SumW-1:0]           credit_used;
    logic                      credit_ok;
    logic                      grant_any;
    logic [IdW-1:0]            grant_id;
    int unsigned               idx;

    logic [MAX_INFO_WIDTH-1:0] win_data;
    enc_mod_t                  win_mod;
    logic                      win_err;
    logic [MAX_INFO_WIDTH-1:0] issue_data;

    logic                          done;
    enc_tag_t                      done_tag;
    logic [MAX_CODEWORD_WIDTH-1:0] done_cw;
    logic [FifoW-1:0]              push_data;
    logic [FifoW-1:0]              head;
    logic [MAX_CODEWORD_WIDTH-1:0] head_cw;
    enc_tag_t                      head_tag;
    logic                          fifo_empty;
    logic                          pop;
    logic                          unused_head_id;

    // Registered counts only: a pop this cycle frees credit next cycle.
    assign credit_used = SumW'(fifo_count) + SumW'(inflight_q);
    assign credit_ok   = (credit_used < SumW'(OUT_DEPTH));

    always_comb begin
        grant_any = 1'b0;
        grant_id  = '0;
        idx       = 0;
        req_ready = '0;
        if (credit_ok && !rst) begin
            for (int unsigned off = 1; off <= NUM_REQ; off++) begin
                idx = 32'(last_ptr_q) + off;
                if (idx >= NUM_REQ) begin
                    idx = idx - NUM_REQ;
                end
                if (!grant_any && req_valid[idx]) begin
                    grant_any = 1'b1;
                    grant_id  = IdW'(idx);
                end
            end
        end
        if (grant_any) begin
            req_ready[grant_id] = 1'b1;
        end
    end

    always_comb begin
        win_data   = req_data[grant_id*MAX_INFO_WIDTH +: MAX_INFO_WIDTH];
        win_mod    = enc_mod_t'(req_mod[grant_id*2 +: 2]);
        win_err    = (win_mod == MOD_NONE);
        issue_data = win_err ? '0 : win_data;
`ifdef ENC_SCHED_MASK_EN
        for (int unsigned b = 0; b < MAX_INFO_WIDTH; b++) begin
            if (b >= info_width(win_mod)) begin
                issue_data[b] = 1'b0;
            end
        end
`else
        // Upper-bit hygiene is left to the requester.
`endif
    end

    assign done     = tag_vld_q[ENC_LATENCY];
    assign done_tag = tag_q[ENC_LATENCY];
    assign done_cw  = done_tag.err ? '0 : enc_data_out;
    assign push_data = {done_cw, done_tag};

    always_comb begin
        last_ptr_d = last_ptr_q;
        enc_data_d = '0;
        enc_mod_d  = MOD_NONE;
        tag_vld_d  = {tag_vld_q[ENC_LATENCY-1:0], grant_any};
        tag_d[0]   = '0;
        for (int unsigned i = 1; i <= ENC_LATENCY; i++) begin
            tag_d[i] = tag_q[i-1];
        end
        if (grant_any) begin
            last_ptr_d   = grant_id;
            enc_data_d   = issue_data;
            enc_mod_d    = win_mod;
            tag_d[0].id  = TagIdW'(grant_id);
            tag_d[0].mod = win_mod;
            tag_d[0].err = win_err;
        end
        unique case ({grant_any, done})
            2'b10:   inflight_d = inflight_q + 1'b1;
            2'b01:   inflight_d = inflight_q - 1'b1;
            default: inflight_d = inflight_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_ptr_q <= IdW'(NUM_REQ - 1);
            inflight_q <= '0;
            enc_data_q <= '0;
            enc_mod_q  <= MOD_NONE;
            tag_vld_q  <= '0;
            for (int unsigned i = 0; i <= ENC_LATENCY; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            last_ptr_q <= last_ptr_d;
            inflight_q <= inflight_d;
            enc_data_q <= enc_data_d;
            enc_mod_q  <= enc_mod_d;
            tag_vld_q  <= tag_vld_d;
            for (int unsigned i = 0; i <= ENC_LATENCY; i++) begin
                tag_q[i] <= tag_d[i];
            end
        end
    end

    assign enc_data_in = enc_data_q;
    assign enc_mod     = enc_mod_q;

    enc_sched_fifo #(
        .Width (FifoW),
        .Depth (OUT_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (done),
        .push_data (push_data),
        .pop       (pop),
        .pop_data  (head),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign rsp_valid = !fifo_empty;
    assign pop       = rsp_valid & rsp_ready;
    assign {head_cw, head_tag} = head;
    assign unused_head_id = ^head_tag.id;

    // Outputs read zero while empty so stale FIFO storage never leaks out.
    always_comb begin
        rsp_data = '0;
        rsp_id   = '0;
        rsp_mod  = '0;
        rsp_err  = 1'b0;
        if (rsp_valid) begin
            rsp_data = head_cw;
            rsp_id   = head_tag.id[IdW-1:0];
            rsp_mod  = head_tag.mod;
            rsp_err  = head_tag.err;
        end
    end

endmodule

// File: tb/tb_enc_sched.sv
// Self-checking bench for enc_sched with a two-stage reference encoder model.
module tb_enc_sched;

    localparam int NR = 4;
    localparam int IW = 26;
    localparam int CW = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic [NR-1:0]     req_valid;
    logic [NR-1:0]     req_ready;
    logic [NR*IW-1:0]  req_data;
    logic [NR*2-1:0]   req_mod;
    logic [IW-1:0]     enc_data_in;
    logic [1:0]        enc_mod;
    logic [CW-1:0]     enc_data_out;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [CW-1:0]     rsp_data;
    logic [1:0]        rsp_id;
    logic [1:0]        rsp_mod;
    logic              rsp_err;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    enc_sched dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_data     (req_data),
        .req_mod      (req_mod),
        .enc_data_in  (enc_data_in),
        .enc_mod      (enc_mod),
        .enc_data_out (enc_data_out),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_data     (rsp_data),
        .rsp_id       (rsp_id),
        .rsp_mod      (rsp_mod),
        .rsp_err      (rsp_err)
    );

    // Hamming-style reference: info bits low, parity bits directly above.
    function automatic logic [CW-1:0] enc_ref(logic [IW-1:0] d, logic [1:0] m);
        int w;
        int p;
        logic [CW-1:0] cw;
        logic par;
        case (m)
            2'd1: begin w = 4;  p = 4; end
            2'd2: begin w = 11; p = 5; end
            2'd3: begin w = 26; p = 6; end
            default: return '0;
        endcase
        cw = '0;
        for (int i = 0; i < w; i++) cw[i] = d[i];
        for (int j = 0; j < p; j++) begin
            par = 1'b0;
            for (int i = 0; i < w; i++) if ((((i + 1) >> j) & 1) == 1) par = par ^ d[i];
            cw[w + j] = par;
        end
        return cw;
    endfunction

    logic [CW-1:0] enc_s1, enc_s2;
    always @(posedge clk) begin
        if (rst) begin
            enc_s1 <= '0;
            enc_s2 <= '0;
        end else begin
            enc_s1 <= enc_ref(enc_data_in, enc_mod);
            enc_s2 <= enc_s1;
        end
    end
    assign enc_data_out = enc_s2;

    typedef struct {
        logic [1:0]    id;
        logic [1:0]    mod;
        logic          err;
        logic [CW-1:0] data;
    } rsp_t;

    rsp_t rsp_q[$];
    int   gnt_q[$];

    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (rsp_valid && rsp_ready) rsp_q.push_back('{rsp_id, rsp_mod, rsp_err, rsp_data});
            for (int i = 0; i < NR; i++) if (req_ready[i]) gnt_q.push_back(i);
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = '0;
        tick();
        tick();
        rst = 1'b0;
        gnt_q.delete();
        rsp_q.delete();
    endtask

    task automatic set_req(input int r, input logic [1:0] m, input logic [IW-1:0] d);
        req_data[r*IW +: IW] = d;
        req_mod[r*2 +: 2]    = m;
        req_valid[r]         = 1'b1;
    endtask

    typedef struct {
        int            req;
        logic [1:0]    mod;
        logic [IW-1:0] data;
        logic [IW-1:0] exp_enc;
        logic [1:0]    exp_mod;
        logic          exp_err;
    } vec_t;

`ifdef ENC_SCHED_MASK_EN
    localparam logic [IW-1:0] MaskedAll = 26'h000000F;
`else
    localparam logic [IW-1:0] MaskedAll = 26'h3FFFFFF;
`endif

    vec_t          vecs[5];
    logic [IW-1:0] sdata[NR];
    logic [NR-1:0] rr;
    int            cnt;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_data  = '0;
        req_mod   = '0;
        rsp_ready = 1'b0;

        vecs[0] = '{2, 2'd1, 26'h000000A, 26'h000000A, 2'd1, 1'b0};
        vecs[1] = '{0, 2'd3, 26'h2ABCDEF, 26'h2ABCDEF, 2'd3, 1'b0};
        vecs[2] = '{1, 2'd2, 26'h00005A5, 26'h00005A5, 2'd2, 1'b0};
        vecs[3] = '{3, 2'd1, 26'h3FFFFFF, MaskedAll,   2'd1, 1'b0};
        vecs[4] = '{1, 2'd0, 26'h0000123, 26'h0000000, 2'd0, 1'b1};
        for (int r = 0; r < NR; r++) sdata[r] = 26'(32'h0123457 * (r + 3));

        // Reset values
        repeat (2) tick();
        @(negedge clk);
        check("rst_req_ready", 64'(req_ready), 64'h0);
        check("rst_enc_data", 64'(enc_data_in), 64'h0);
        check("rst_enc_mod", 64'(enc_mod), 64'h0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'h0);
        check("rst_rsp_fields", 64'({rsp_data, rsp_id, rsp_mod, rsp_err}), 64'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        rsp_ready = 1'b1;

        // Single-request vectors with exact latency
        for (int v = 0; v < 5; v++) begin
            set_req(vecs[v].req, vecs[v].mod, vecs[v].data);
            @(negedge clk);
            check("vec_ready", 64'(req_ready), 64'(4'b0001 << vecs[v].req));
            tick();
            req_valid = '0;
            @(negedge clk);
            check("vec_enc_data", 64'(enc_data_in), 64'(vecs[v].exp_enc));
            check("vec_enc_mod", 64'(enc_mod), 64'(vecs[v].exp_mod));
            @(negedge clk);
            @(negedge clk);
            check("vec_rsp_early", 64'(rsp_valid), 64'h0);
            @(negedge clk);
            check("vec_rsp_valid", 64'(rsp_valid), 64'h1);
            check("vec_rsp_id", 64'(rsp_id), 64'(vecs[v].req));
            check("vec_rsp_mod", 64'(rsp_mod), 64'(vecs[v].mod));
            check("vec_rsp_err", 64'(rsp_err), 64'(vecs[v].exp_err));
            check("vec_rsp_data", 64'(rsp_data), 64'(enc_ref(vecs[v].data, vecs[v].mod)));
            tick();
        end

        // All requesters streaming: rotating grants, responses in grant order
        do_reset();
        rsp_ready = 1'b1;
        for (int r = 0; r < NR; r++) set_req(r, 2'd3, sdata[r]);
        repeat (20) tick();
        req_valid = '0;
        repeat (10) tick();
        check("stream_enough_grants", 64'(gnt_q.size() >= 12), 64'h1);
        check("stream_rsp_count", 64'(rsp_q.size()), 64'(gnt_q.size()));
        for (int i = 0; i < 12 && i < gnt_q.size(); i++) check("stream_grant_order", 64'(gnt_q[i]), 64'(i % NR));
        for (int i = 0; i < 12 && i < rsp_q.size(); i++) begin
            check("stream_rsp_id", 64'(rsp_q[i].id), 64'(i % NR));
            check("stream_rsp_data", 64'(rsp_q[i].data), 64'(enc_ref(sdata[i % NR], 2'd3)));
        end

        // Back-pressure: exactly OUT_DEPTH accepts, resume one cycle after first pop
        do_reset();
        rsp_ready = 1'b0;
        set_req(0, 2'd1, 26'h5);
        repeat (12) tick();
        check("bp_accepts", 64'(gnt_q.size()), 64'd4);
        @(negedge clk);
        check("bp_ready_low", 64'(req_ready), 64'h0);
        check("bp_rsp_valid", 64'(rsp_valid), 64'h1);
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_pop_cycle_ready", 64'(req_ready), 64'h0);
        tick();
        @(negedge clk);
        check("bp_resume_ready", 64'(req_ready), 64'h1);
        tick();
        req_valid = '0;
        repeat (10) tick();
        check("bp_total_grants", 64'(gnt_q.size()), 64'd5);
        check("bp_total_rsps", 64'(rsp_q.size()), 64'd5);

        // Illegal mode between two legal requests
        do_reset();
        rsp_ready = 1'b1;
        set_req(0, 2'd3, 26'h1555555);
        set_req(1, 2'd0, 26'h3FFFFFF);
        set_req(2, 2'd3, 26'h0F0F0F0);
        repeat (12) begin
            @(negedge clk);
            rr = req_ready;
            tick();
            req_valid = req_valid & ~rr;
        end
        check("ill_rsp_count", 64'(rsp_q.size()), 64'd3);
        if (rsp_q.size() == 3) begin
            check("ill_id0", 64'(rsp_q[0].id), 64'd0);
            check("ill_err0", 64'(rsp_q[0].err), 64'd0);
            check("ill_data0", 64'(rsp_q[0].data), 64'(enc_ref(26'h1555555, 2'd3)));
            check("ill_id1", 64'(rsp_q[1].id), 64'd1);
            check("ill_err1", 64'(rsp_q[1].err), 64'd1);
            check("ill_mod1", 64'(rsp_q[1].mod), 64'd0);
            check("ill_data1", 64'(rsp_q[1].data), 64'h0);
            check("ill_id2", 64'(rsp_q[2].id), 64'd2);
            check("ill_err2", 64'(rsp_q[2].err), 64'd0);
            check("ill_data2", 64'(rsp_q[2].data), 64'(enc_ref(26'h0F0F0F0, 2'd3)));
        end

        // Reset with three requests in flight
        do_reset();
        rsp_ready = 1'b1;
        for (int r = 0; r < NR; r++) set_req(r, 2'd2, sdata[r]);
        repeat (3) tick();
        check("mid_pre_grants", 64'(gnt_q.size()), 64'd3);
        rst = 1'b1;
        req_valid = '0;
        tick();
        rst = 1'b0;
        gnt_q.delete();
        rsp_q.delete();
        cnt = 0;
        repeat (8) begin
            @(negedge clk);
            if (rsp_valid) cnt++;
        end
        check("mid_no_rsp", 64'(cnt), 64'd0);
        @(posedge clk);
        #1;
        req_valid = 4'b1001;
        @(negedge clk);
        check("mid_first_grant", 64'(req_ready), 64'b0001);
        tick();
        req_valid[0] = 1'b0;
        @(negedge clk);
        check("mid_second_grant", 64'(req_ready), 64'b1000);
        tick();
        req_valid = '0;
        repeat (8) tick();
        check("mid_rsp_count", 64'(rsp_q.size()), 64'd2);
        if (rsp_q.size() == 2) begin
            check("mid_rsp_id0", 64'(rsp_q[0].id), 64'd0);
            check("mid_rsp_id1", 64'(rsp_q[1].id), 64'd3);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
